// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared constants and state type for the normalisation controller
package norm_pkg;

  localparam int DATA_W = 8;               // operand width; the barrel shifter is fixed at 8
  localparam int SH_W   = 4;               // shift-code width, 2**SH_W > DATA_W
  localparam int CNT_W  = $clog2(DATA_W);  // scan counter / bit index width

  localparam logic [SH_W-1:0] SH_ZERO     = SH_W'(0);
  localparam logic [SH_W-1:0] SH_MAX_LEFT = SH_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/norm_shift_ctrl_if.sv
// rtl/norm_shift_ctrl_if.sv - operand/result handshake bundle for the normalisation controller
//
// Signals:
//   in_valid, in_data   operand offered by the source
//   in_ready            controller can accept an operand
//   out_valid, out_data result: held operand
//   out_sh, out_zero    left-shift code and all-zero flag
//   out_ready           downstream consumes the result
// Modports: master = operand source / result sink, slave = controller.
interface norm_shift_ctrl_if;
  import norm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SH_W-1:0]   out_sh;
  logic              out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sh, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sh, out_zero
  );

endinterface

// File: rtl/norm_shift_ctrl.sv
// rtl/norm_shift_ctrl.sv - leading-zero scan controller feeding the barrel shifter
//
// Latches an operand, scans it MSB-first one bit per cycle and presents the
// operand plus the left-shift code that left-justifies it, with an all-zero flag.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  norm_shift_ctrl_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/
//        out_data/out_sh/out_zero)
// Optional feature macro: NORM_FAST_ZERO_EN (all-zero operand goes IDLE->DONE at accept).
module norm_shift_ctrl
  import norm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  norm_shift_ctrl_if.slave    bus
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [SH_W-1:0]   sh_q, sh_n;
  logic              zero_q, zero_n;

  logic [CNT_W-1:0]  idx;
  logic              scan_bit;

  // cnt counts leading zeros seen so far; idx walks from the MSB downward.
  assign idx      = CNT_W'(DATA_W - 1) - cnt;
  assign scan_bit = data_q[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      sh_q   <= SH_ZERO;
      zero_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      sh_q   <= sh_n;
      zero_q <= zero_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data_q;
    sh_n    = sh_q;
    zero_n  = zero_q;
    case (state)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks the accept.
        if (bus.in_valid) begin
          data_n = bus.in_data;
          cnt_n  = '0;
          zero_n = 1'b0;
`ifdef NORM_FAST_ZERO_EN
          if (bus.in_data == '0) begin
            sh_n    = SH_ZERO;
            zero_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = SCAN;
          end
`else
          state_n = SCAN;
`endif
        end
      end
      SCAN: begin
        if (scan_bit) begin
          sh_n    = SH_W'(cnt);
          state_n = DONE;
        end else if (cnt != CNT_W'(SH_MAX_LEFT)) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          // Scanned every bit without finding a one.
          sh_n    = SH_ZERO;
          zero_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first means the next operand is taken a cycle later.
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_sh    = sh_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// tb/tb_norm_shift_ctrl.sv - self-checking bench for norm_shift_ctrl chained to a shifter model
module tb_norm_shift_ctrl;
  import norm_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [3:0] sh;
    logic       zero;
    logic [7:0] norm;
    int         lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  norm_shift_ctrl_if bus();

  norm_shift_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream barrel shifter model: left shift by the presented code.
  function automatic logic [7:0] shifter(input logic [7:0] d, input logic [3:0] sh);
    return d << sh;
  endfunction

  function automatic exp_t ref_exp(input logic [7:0] d);
    exp_t e;
    int   lz;
    logic [7:0] v;
    e.data = d;
    lz = 0;
    v  = d;
    if (d == 8'h00) begin
      e.sh   = 4'd0;
      e.zero = 1'b1;
      e.norm = 8'h00;
`ifdef NORM_FAST_ZERO_EN
      e.lat  = 0;  // out_valid is already up right after the accept edge
`else
      e.lat  = 8;
`endif
    end else begin
      while (v[7] == 1'b0) begin
        v  = v << 1;
        lz = lz + 1;
      end
      e.sh   = 4'(lz);
      e.zero = 1'b0;
      e.norm = v;
      e.lat  = lz + 1;
    end
    return e;
  endfunction

  // Called at posedge+1 while the controller is IDLE; the next edge accepts.
  task automatic accept(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    sb.push_back(ref_exp(d));
  endtask

  // Edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = -1;
    if (bus.out_valid) begin
      edges = 0;
    end else begin
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) begin
          edges = i;
          break;
        end
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_sh !== 4'd0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h out_sh=%0d out_zero=%b, required 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_sh, bus.out_zero);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] tbl [3];
    int   edges;
    exp_t e;
    tbl[0] = 8'h80;
    tbl[1] = 8'h01;
    tbl[2] = 8'h00;
    for (int t = 0; t < 3; t++) begin
      accept(tbl[t]);
      wait_valid(edges);
      e = sb.pop_front();
      checks++;
      if (edges !== e.lat) begin
        failures++;
        $display("FAIL single_latency op=%h: got %0d edges, required %0d", tbl[t], edges, e.lat);
      end
      checks++;
      if (bus.out_sh !== e.sh || bus.out_zero !== e.zero || bus.out_data !== e.data) begin
        failures++;
        $display("FAIL single_result op=%h: sh=%0d zero=%b data=%h, required sh=%0d zero=%b data=%h",
                 tbl[t], bus.out_sh, bus.out_zero, bus.out_data, e.sh, e.zero, e.data);
      end
      checks++;
      if (shifter(bus.out_data, bus.out_sh) !== e.norm) begin
        failures++;
        $display("FAIL single_shifter op=%h: got %h, required %h",
                 tbl[t], shifter(bus.out_data, bus.out_sh), e.norm);
      end
      release_out();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL single_release op=%h: out_valid=%b in_ready=%b, required 0 1",
                 tbl[t], bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_stall();
    int   edges;
    exp_t e;
    accept(8'h13);
    wait_valid(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== e.lat || bus.out_sh !== 4'd3) begin
      failures++;
      $display("FAIL stall_first: edges=%0d sh=%0d, required edges=%0d sh=3", edges, bus.out_sh, e.lat);
    end
    // Offer a second operand while the result is stalled; it must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h40;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sh !== 4'd3 || bus.out_data !== 8'h13 ||
          bus.out_zero !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: valid=%b sh=%0d data=%h zero=%b in_ready=%b, required 1 3 13 0 0",
                 c, bus.out_valid, bus.out_sh, bus.out_data, bus.out_zero, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h13) begin
      failures++;
      $display("FAIL stall_no_same_cycle_accept: in_ready=%b out_valid=%b data=%h, required 1 0 13",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    accept(8'h40);
    wait_valid(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== 2 || bus.out_sh !== 4'd1 || bus.out_data !== 8'h40) begin
      failures++;
      $display("FAIL stall_second: edges=%0d sh=%0d data=%h, required edges=2 sh=1 data=40",
               edges, bus.out_sh, bus.out_data);
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    int   edges;
    exp_t e;
    accept(8'h02);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_scanning: out_valid=%b in_ready=%b, required 0 0", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_sh !== 4'd0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: in_ready=%b out_valid=%b data=%h sh=%0d zero=%b, required 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_sh, bus.out_zero);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    accept(8'h40);
    wait_valid(edges);
    e = sb.pop_front();
    checks++;
    if (edges !== e.lat || edges !== 2 || bus.out_sh !== 4'd1 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL midrst_next: edges=%0d sh=%0d zero=%b, required edges=2 sh=1 zero=0",
               edges, bus.out_sh, bus.out_zero);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int         edges;
    exp_t       e;
    logic [7:0] d;
    logic [7:0] s;
    for (int n = 0; n < 500; n++) begin
      d = 8'($urandom_range(1, 255));
      accept(d);
      wait_valid(edges);
      e = sb.pop_front();
      s = shifter(bus.out_data, bus.out_sh);
      checks++;
      if (edges !== e.lat || bus.out_sh !== e.sh || bus.out_zero !== 1'b0 || bus.out_data !== e.data) begin
        failures++;
        $display("FAIL b2b op=%h: edges=%0d sh=%0d zero=%b data=%h, required edges=%0d sh=%0d zero=0 data=%h",
                 d, edges, bus.out_sh, bus.out_zero, bus.out_data, e.lat, e.sh, e.data);
      end
      checks++;
      if (s !== e.norm || s[7] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_shifter op=%h: got %h, required %h with bit7 set", d, s, e.norm);
      end
      release_out();
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
